// File: rtl/seq_mult_if.sv
// Operand/result bundle for seq_mult: operands flow producer -> multiplier,
// and the registered product with its valid pulse flows back.
interface seq_mult_if #(
  parameter int Multiplicand_length = 5,
  parameter int Multiplier_length   = 2
);
  logic [Multiplicand_length-1:0]                 a;
  logic [Multiplier_length-1:0]                   b;
  logic                                           ab_valid;
  logic                                           ab_ready;
  logic [Multiplicand_length+Multiplier_length-1:0] z;
  logic                                           z_valid;

  // Operands transfer on a rising edge where ab_valid and ab_ready are both 1;
  // ab_valid without ab_ready is dropped (never queued), and z_valid is a
  // one-cycle pulse with no back-pressure.
  modport master (
    output a, b, ab_valid,
    input  ab_ready, z, z_valid
  );

  modport slave (
    input  a, b, ab_valid,
    output ab_ready, z, z_valid
  );
endinterface

// File: rtl/seq_mult.sv
// Unsigned shift-and-add multiplier: one multiplier bit per clock, LSB first,
// so a product takes Multiplier_length cycles after the operands are accepted.
module seq_mult #(
  parameter int Multiplicand_length = 5,
  parameter int Multiplier_length   = 2
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult_if.slave  bus,
  output logic       dbg_state
);
  localparam int M  = Multiplicand_length;
  localparam int N  = Multiplier_length;
  localparam int P  = M + N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [P-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [P-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [P-1:0]  z_q, z_d;
  logic          z_valid_q, z_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
    end
  end

  // a_q shifts left and b_q shifts right each BUSY cycle, so the current
  // multiplier bit is always b_q[0] and its weight is already applied to a_q.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    z_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ab_valid) begin
          a_d     = {{N{1'b0}}, bus.a};
          b_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // Final bit: publish the sum including this bit's partial product.
        if (cnt_q == LAST) begin
          z_d       = acc_d;
          z_valid_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ab_ready = (state_q == IDLE);
  assign bus.z        = z_q;
  assign bus.z_valid  = z_valid_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult with default widths (5x2): hand-computed
// products, a cycle model of the handshake and an expected-product queue.
module tb_seq_mult;
  localparam int M = 5;
  localparam int N = 2;
  localparam int P = M + N;

  logic clk;
  logic rst;
  logic dbg_state;

  seq_mult_if #(.Multiplicand_length(M), .Multiplier_length(N)) bus ();

  seq_mult #(.Multiplicand_length(M), .Multiplier_length(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [P-1:0] exp_q[$];
  logic         m_busy;
  int           m_cnt;
  logic [P-1:0] m_prod;
  logic [P-1:0] m_z;
  logic         m_zv;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_prod <= '0;
      m_z    <= '0;
      m_zv   <= 1'b0;
      exp_q.delete();
    end else begin
      m_zv <= 1'b0;
      if (!m_busy) begin
        if (bus.ab_valid) begin
          m_busy <= 1'b1;
          m_cnt  <= 1;
          m_prod <= P'(bus.a) * P'(bus.b);
          exp_q.push_back(P'(bus.a) * P'(bus.b));
        end
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == N) begin
          m_z    <= m_prod;
          m_zv   <= 1'b1;
          m_busy <= 1'b0;
        end
      end
    end
  end

  bit chk_en = 0;
  bit b2b_en = 0;
  int dut_acc = 0;
  int cyc = 0;
  int last_acc_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("ab_ready", bus.ab_ready, !m_busy);
      check("z_valid", bus.z_valid, m_zv);
      check("z", bus.z, m_z);
      check("dbg_state", dbg_state, m_busy);
      if (bus.z_valid === 1'b1) begin
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else check("sb_z", bus.z, exp_q.pop_front());
      end
      if (b2b_en && bus.ab_valid === 1'b1 && bus.ab_ready === 1'b1) begin
        dut_acc++;
        if (last_acc_cyc >= 0) check("accept_gap", cyc - last_acc_cyc, N + 1);
        last_acc_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair for a single edge and checks the full latency profile.
  task automatic op(input logic [M-1:0] a, input logic [N-1:0] b, input logic [P-1:0] exp_z,
                    input string tag);
    logic [P-1:0] z_hold;
    bus.a = a; bus.b = b; bus.ab_valid = 1'b1;
    tick();
    bus.ab_valid = 1'b0;
    check({tag, "_ready_busy"}, bus.ab_ready, 1'b0);
    for (int i = 1; i < N; i++) begin
      tick();
      check({tag, "_ready_busy"}, bus.ab_ready, 1'b0);
      check({tag, "_no_early_zv"}, bus.z_valid, 1'b0);
    end
    tick();
    check({tag, "_zv"}, bus.z_valid, 1'b1);
    check({tag, "_z"}, bus.z, exp_z);
    check({tag, "_ready_done"}, bus.ab_ready, 1'b1);
    z_hold = bus.z;
    tick();
    check({tag, "_zv_pulse"}, bus.z_valid, 1'b0);
    check({tag, "_z_hold"}, bus.z, exp_z);
    check({tag, "_z_stable"}, bus.z, z_hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus.a = '0; bus.b = '0; bus.ab_valid = 1'b0;
    #2;
    chk_en = 1;

    // reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      bus.a = M'($urandom_range(0, 31));
      bus.b = N'($urandom_range(0, 3));
      bus.ab_valid = 1'($urandom_range(0, 1));
      tick();
      check("rst_ready", bus.ab_ready, 1'b1);
      check("rst_z", bus.z, 0);
      check("rst_zv", bus.z_valid, 1'b0);
    end
    bus.ab_valid = 1'b0;
    rst = 1'b1;
    tick();

    // single product and edge values
    op(5'd31, 2'd3, 7'd93, "max");
    op(5'd0,  2'd3, 7'd0,  "a_zero");
    op(5'd31, 2'd0, 7'd0,  "b_zero");
    op(5'd1,  2'd1, 7'd1,  "one");
    op(5'd17, 2'd2, 7'd34, "mid");

    // operand stability: a second pair held during BUSY must not disturb
    bus.a = 5'd5; bus.b = 2'd2; bus.ab_valid = 1'b1;
    tick();
    bus.a = 5'd31; bus.b = 2'd3;
    check("stab_ready", bus.ab_ready, 1'b0);
    tick();
    check("stab_busy", bus.ab_ready, 1'b0);
    tick();
    check("stab_zv", bus.z_valid, 1'b1);
    check("stab_z", bus.z, 10);
    tick();
    bus.ab_valid = 1'b0;
    check("stab_second_acc", bus.ab_ready, 1'b0);
    tick();
    tick();
    check("stab_second_zv", bus.z_valid, 1'b1);
    check("stab_second_z", bus.z, 93);
    tick();

    // back-to-back with a fresh pair every cycle
    b2b_en = 1;
    for (int i = 0; i < 50; i++) begin
      bus.a = M'($urandom_range(0, 31));
      bus.b = N'($urandom_range(0, 3));
      bus.ab_valid = 1'b1;
      tick();
    end
    bus.ab_valid = 1'b0;
    b2b_en = 0;
    check("b2b_accepts", dut_acc, 17);
    for (int i = 0; i < N + 2; i++) tick();
    check("b2b_drained", exp_q.size(), 0);

    // reset in the middle of a product
    op(5'd9, 2'd3, 7'd27, "pre_rst");
    bus.a = 5'd7; bus.b = 2'd3; bus.ab_valid = 1'b1;
    tick();
    bus.ab_valid = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", bus.ab_ready, 1'b1);
    check("arst_z", bus.z, 0);
    check("arst_zv", bus.z_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_hold_zv", bus.z_valid, 1'b0);
      check("arst_hold_z", bus.z, 0);
    end
    rst = 1'b1;
    tick();
    check("post_rst_zv", bus.z_valid, 1'b0);
    op(5'd3, 2'd2, 7'd6, "post_rst");
    op(5'd31, 2'd1, 7'd31, "a_times_one");

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
